uart_frame_rx: RTL and testbench

Byte-to-frame receiver sitting directly downstream of the UART receiver. Consumes its one-cycle data-valid strobe and received byte, and hunts for a start-of-frame byte. Assembles length-prefixed, checksummed frames into an internal payload buffer, then hands verified payload bytes to the command logic over a valid/ready stream. Malformed, late or overrunning frames are discarded and reported with a one-cycle error pulse and code.

---
 rtl/uart_frame_rx.sv | 217 +++++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// uart_frame_rx
// Byte-to-frame receiver placed directly after a UART receiver. It hunts for a
// start-of-frame marker, then collects a frame of the form
//   SOF_BYTE, LEN, LEN payload bytes, CHK
// into a payload buffer. A frame is valid when (LEN + payload + CHK) mod 256 == 0.
// Verified payload bytes are streamed out on a valid/ready interface; malformed,
// late or overrunning frames are dropped and reported with a one-cycle error
// pulse plus a code.
//
// Optional feature macro: UART_FRAME_TIMEOUT_EN
//   defined   -> inter-byte timeout counter present (TIMEOUT error, code 2)
//   undefined -> no timeout; a partial frame waits indefinitely
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   i_RX_DV       in   one-cycle byte strobe from the UART receiver
//   i_RX_Byte     in   [7:0] received byte, valid with i_RX_DV
//   o_Data_Valid  out  payload byte available
//   o_Data_Byte   out  [7:0] current payload byte
//   o_Data_Last   out  current byte is the last of the frame
//   i_Data_Ready  in   consumer ready
//   o_Frame_Ok    out  one-cycle pulse on checksum pass
//   o_Frame_Err   out  one-cycle pulse on any error
//   o_Err_Code    out  [1:0] 0 BADLEN, 1 BADCHK, 2 TIMEOUT, 3 OVERRUN (held)
//   o_State_Dbg   out  [2:0] current FSM state (debug/observability)
//
// Handshake: a payload byte transfers on a rising edge where o_Data_Valid and
// i_Data_Ready are both high. While o_Data_Valid is high and i_Data_Ready low,
// o_Data_Byte and o_Data_Last hold. All stream outputs are registered, so there
// is no combinational path from i_Data_Ready to any output.

module uart_frame_rx #(
  parameter int unsigned MAX_PAYLOAD  = 16,
  parameter logic [7:0]  SOF_BYTE     = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_Data_Valid,
  output logic [7:0] o_Data_Byte,
  output logic       o_Data_Last,
  input  logic       i_Data_Ready,
  output logic       o_Frame_Ok,
  output logic       o_Frame_Err,
  output logic [1:0] o_Err_Code,
  output logic [2:0] o_State_Dbg
);

  localparam int unsigned AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [7:0]  MAX_LEN = 8'(MAX_PAYLOAD);

  localparam logic [1:0] ERR_BADLEN  = 2'd0;
  localparam logic [1:0] ERR_BADCHK  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DELIVER = 3'd4
  } state_e;

  state_e     state_q;
  logic [7:0] len_q;
  logic [7:0] sum_q;
  logic [7:0] wr_idx_q;
  logic [7:0] rd_idx_q;
  logic [7:0] buf_q [MAX_PAYLOAD];

  logic [7:0] rd_idx_d;
  logic [7:0] sum_d;
  logic [7:0] len_m1;
  logic       handshake;
  logic       timeout_hit;

  assign rd_idx_d    = rd_idx_q + 8'd1;
  assign sum_d       = sum_q + i_RX_Byte;
  assign len_m1      = len_q - 8'd1;
  assign handshake   = o_Data_Valid & i_Data_Ready;
  assign o_State_Dbg = state_q;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] to_cnt_q;

  // Counts idle cycles since the last accepted byte; only meaningful while a
  // frame is being assembled (LEN, PAYLOAD, CHECK).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (state_q == ST_HUNT || state_q == ST_DELIVER || i_RX_DV) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (to_cnt_q == TW'(TIMEOUT_CLKS - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Payload storage; contents only matter during delivery, so no reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_PAYLOAD && i_RX_DV) begin
      buf_q[wr_idx_q[AW-1:0]] <= i_RX_Byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HUNT;
      len_q        <= '0;
      sum_q        <= '0;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      o_Data_Valid <= 1'b0;
      o_Data_Byte  <= '0;
      o_Data_Last  <= 1'b0;
      o_Frame_Ok   <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Err_Code   <= '0;
    end else begin
      o_Frame_Ok  <= 1'b0;
      o_Frame_Err <= 1'b0;
      unique case (state_q)
        ST_HUNT: begin
          if (i_RX_DV && i_RX_Byte == SOF_BYTE) begin
            sum_q   <= '0;
            state_q <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (i_RX_DV) begin
            if (i_RX_Byte == 8'd0 || i_RX_Byte > MAX_LEN) begin
              o_Frame_Err <= 1'b1;
              o_Err_Code  <= ERR_BADLEN;
              state_q     <= ST_HUNT;
            end else begin
              len_q    <= i_RX_Byte;
              sum_q    <= i_RX_Byte;
              wr_idx_q <= '0;
              state_q  <= ST_PAYLOAD;
            end
          end else if (timeout_hit) begin
            o_Frame_Err <= 1'b1;
            o_Err_Code  <= ERR_TIMEOUT;
            state_q     <= ST_HUNT;
          end
        end
        ST_PAYLOAD: begin
          if (i_RX_DV) begin
            sum_q    <= sum_d;
            wr_idx_q <= wr_idx_q + 8'd1;
            if (wr_idx_q == len_m1) begin
              state_q <= ST_CHECK;
            end
          end else if (timeout_hit) begin
            o_Frame_Err <= 1'b1;
            o_Err_Code  <= ERR_TIMEOUT;
            state_q     <= ST_HUNT;
          end
        end
        ST_CHECK: begin
          if (i_RX_DV) begin
            if (sum_d == 8'd0) begin
              // Present the first byte right away so delivery starts the
              // cycle after the CHK strobe.
              o_Frame_Ok   <= 1'b1;
              rd_idx_q     <= '0;
              o_Data_Valid <= 1'b1;
              o_Data_Byte  <= buf_q[0];
              o_Data_Last  <= (len_q == 8'd1);
              state_q      <= ST_DELIVER;
            end else begin
              o_Frame_Err <= 1'b1;
              o_Err_Code  <= ERR_BADCHK;
              state_q     <= ST_HUNT;
            end
          end else if (timeout_hit) begin
            o_Frame_Err <= 1'b1;
            o_Err_Code  <= ERR_TIMEOUT;
            state_q     <= ST_HUNT;
          end
        end
        ST_DELIVER: begin
          // Any incoming byte is dropped here, including on the final
          // handshake cycle, so it is never mistaken for a new SOF.
          if (i_RX_DV) begin
            o_Frame_Err <= 1'b1;
            o_Err_Code  <= ERR_OVERRUN;
          end
          if (handshake) begin
            if (o_Data_Last) begin
              o_Data_Valid <= 1'b0;
              o_Data_Last  <= 1'b0;
              state_q      <= ST_HUNT;
            end else begin
              rd_idx_q    <= rd_idx_d;
              o_Data_Byte <= buf_q[rd_idx_d[AW-1:0]];
              o_Data_Last <= (rd_idx_d == len_m1);
            end
          end
        end
        default: begin
          state_q <= ST_HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
`timescale 1ns/1ps

module tb_uart_frame_rx;

  localparam int MAX_PAYLOAD  = 16;
  localparam int TIMEOUT_CLKS = 100;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_RX_DV = 1'b0;
  logic [7:0] i_RX_Byte = 8'h00;
  logic       i_Data_Ready = 1'b0;
  logic       o_Data_Valid;
  logic [7:0] o_Data_Byte;
  logic       o_Data_Last;
  logic       o_Frame_Ok;
  logic       o_Frame_Err;
  logic [1:0] o_Err_Code;
  logic [2:0] o_State_Dbg;

  always #5 clk = ~clk;

  uart_frame_rx #(
    .MAX_PAYLOAD (MAX_PAYLOAD),
    .SOF_BYTE    (8'hA5),
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_RX_DV     (i_RX_DV),
    .i_RX_Byte   (i_RX_Byte),
    .o_Data_Valid(o_Data_Valid),
    .o_Data_Byte (o_Data_Byte),
    .o_Data_Last (o_Data_Last),
    .i_Data_Ready(i_Data_Ready),
    .o_Frame_Ok  (o_Frame_Ok),
    .o_Frame_Err (o_Frame_Err),
    .o_Err_Code  (o_Err_Code),
    .o_State_Dbg (o_State_Dbg)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         failures = 0;
  int         ok_seen = 0;
  int         ok_exp = 0;
  logic [8:0] exp_q[$];   // {last, byte} of each expected payload transfer
  logic [1:0] err_q[$];   // expected error codes, in order
  logic [7:0] tx_q[$];    // bytes to send

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_Data_Valid && i_Data_Ready) begin
        check("data_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          check("data_byte_last", {23'd0, o_Data_Last, o_Data_Byte}, {23'd0, exp_q.pop_front()});
        end
      end
      if (o_Frame_Err) begin
        check("err_expected", 32'(err_q.size() > 0), 32'd1);
        if (err_q.size() > 0) begin
          check("err_code", {30'd0, o_Err_Code}, {30'd0, err_q.pop_front()});
        end
      end
      if (o_Frame_Ok) ok_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  // All steps start and end just after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_RX_DV   = 1'b1;
    i_RX_Byte = b;
    @(posedge clk);
    #1;
    i_RX_DV = 1'b0;
  endtask

  // Sends tx_q with one idle cycle between bytes; returns right after the
  // edge that sampled the last byte.
  task automatic send_tx();
    while (tx_q.size() > 0) begin
      send_byte(tx_q.pop_front());
      if (tx_q.size() > 0) idle(1);
    end
  endtask

  task automatic expect_good_113();
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h33});
    ok_exp++;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int         n;
    logic [7:0] chk;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, o_Data_Valid}, 32'd0);
    check("rst_byte",  {24'd0, o_Data_Byte}, 32'd0);
    check("rst_last",  {31'd0, o_Data_Last}, 32'd0);
    check("rst_ok",    {31'd0, o_Frame_Ok}, 32'd0);
    check("rst_err",   {31'd0, o_Frame_Err}, 32'd0);
    check("rst_code",  {30'd0, o_Err_Code}, 32'd0);
    check("rst_state", {29'd0, o_State_Dbg}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Good frame, consumer always ready.
    i_Data_Ready = 1'b1;
    expect_good_113();
    tx_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_tx();
    check("good_ok_latency", {31'd0, o_Frame_Ok}, 32'd1);
    check("good_valid_latency", {31'd0, o_Data_Valid}, 32'd1);
    check("good_first_byte", {24'd0, o_Data_Byte}, 32'h11);
    idle(3);
    check("good_drained", {31'd0, o_Data_Valid}, 32'd0);
    check("good_hunt", {29'd0, o_State_Dbg}, 32'd0);

    // Backpressure: hold for 5 cycles.
    i_Data_Ready = 1'b0;
    expect_good_113();
    tx_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_tx();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", {31'd0, o_Data_Valid}, 32'd1);
      check("bp_byte_held", {24'd0, o_Data_Byte}, 32'h11);
      idle(1);
    end
    i_Data_Ready = 1'b1;
    idle(3);
    check("bp_drained", {31'd0, o_Data_Valid}, 32'd0);

    // Bad checksum, then a good frame.
    err_q.push_back(2'd1);
    tx_q = {8'hA5, 8'h02, 8'h01, 8'h02, 8'h00};
    send_tx();
    check("badchk_err", {31'd0, o_Frame_Err}, 32'd1);
    check("badchk_code", {30'd0, o_Err_Code}, 32'd1);
    check("badchk_no_valid", {31'd0, o_Data_Valid}, 32'd0);
    exp_q.push_back({1'b1, 8'h7F});
    ok_exp++;
    tx_q = {8'hA5, 8'h01, 8'h7F, 8'h80};
    send_tx();
    idle(1);
    check("after_badchk_drained", {31'd0, o_Data_Valid}, 32'd0);

    // Bad lengths, with leading garbage.
    err_q.push_back(2'd0);
    tx_q = {8'h00, 8'hFF, 8'hA5, 8'h00};
    send_tx();
    check("badlen0_err", {31'd0, o_Frame_Err}, 32'd1);
    check("badlen0_code", {30'd0, o_Err_Code}, 32'd0);
    err_q.push_back(2'd0);
    tx_q = {8'hA5, 8'h11};
    send_tx();
    check("badlen17_err", {31'd0, o_Frame_Err}, 32'd1);
    check("badlen17_hunt", {29'd0, o_State_Dbg}, 32'd0);

    // Largest legal length.
    chk = 8'(MAX_PAYLOAD);
    tx_q = {8'hA5, 8'(MAX_PAYLOAD)};
    for (int i = 0; i < MAX_PAYLOAD; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      tx_q.push_back(b);
      exp_q.push_back({(i == MAX_PAYLOAD - 1), b});
      chk = chk + b;
    end
    tx_q.push_back(8'h00 - chk);
    ok_exp++;
    send_tx();
    check("maxlen_ok", {31'd0, o_Frame_Ok}, 32'd1);
    idle(MAX_PAYLOAD);
    check("maxlen_drained", {31'd0, o_Data_Valid}, 32'd0);

`ifdef UART_FRAME_TIMEOUT_EN
    // Stall mid-payload until the inter-byte timeout fires.
    err_q.push_back(2'd2);
    tx_q = {8'hA5, 8'h02, 8'h01};
    send_tx();
    n = 0;
    while (!o_Frame_Err && n < TIMEOUT_CLKS + 20) begin
      idle(1);
      n++;
    end
    check("timeout_seen", {31'd0, o_Frame_Err}, 32'd1);
    check("timeout_window", 32'(n >= TIMEOUT_CLKS - 1 && n <= TIMEOUT_CLKS + 1), 32'd1);
    exp_q.push_back({1'b1, 8'h7F});
    ok_exp++;
    tx_q = {8'hA5, 8'h01, 8'h7F, 8'h80};
    send_tx();
    idle(1);
    check("after_timeout_drained", {31'd0, o_Data_Valid}, 32'd0);
`else
    // Without the timeout a stalled frame simply waits.
    tx_q = {8'hA5, 8'h02, 8'h01};
    send_tx();
    idle(TIMEOUT_CLKS + 50);
    check("notimeout_still_payload", {29'd0, o_State_Dbg}, 32'd2);
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b1, 8'h02});
    ok_exp++;
    tx_q = {8'h02, 8'hFB};
    send_tx();
    idle(2);
    check("notimeout_drained", {31'd0, o_Data_Valid}, 32'd0);
`endif

    // Overrun while stalled: byte dropped, payload intact.
    i_Data_Ready = 1'b0;
    exp_q.push_back({1'b0, 8'hAA});
    exp_q.push_back({1'b1, 8'hBB});
    ok_exp++;
    tx_q = {8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h99};
    send_tx();
    idle(1);
    err_q.push_back(2'd3);
    send_byte(8'h5A);
    check("overrun_err", {31'd0, o_Frame_Err}, 32'd1);
    check("overrun_code", {30'd0, o_Err_Code}, 32'd3);
    check("overrun_valid", {31'd0, o_Data_Valid}, 32'd1);
    check("overrun_byte", {24'd0, o_Data_Byte}, 32'hAA);
    i_Data_Ready = 1'b1;
    idle(2);
    check("overrun_drained", {31'd0, o_Data_Valid}, 32'd0);

    // Overrun on the final handshake cycle: SOF byte must not start a frame.
    i_Data_Ready = 1'b0;
    exp_q.push_back({1'b1, 8'h7F});
    ok_exp++;
    tx_q = {8'hA5, 8'h01, 8'h7F, 8'h80};
    send_tx();
    idle(1);
    err_q.push_back(2'd3);
    i_Data_Ready = 1'b1;
    send_byte(8'hA5);
    i_Data_Ready = 1'b0;
    check("lastovr_err", {31'd0, o_Frame_Err}, 32'd1);
    check("lastovr_valid", {31'd0, o_Data_Valid}, 32'd0);
    check("lastovr_hunt", {29'd0, o_State_Dbg}, 32'd0);

    // Reset mid-payload.
    tx_q = {8'hA5, 8'h04, 8'h01, 8'h02};
    send_tx();
    check("midpay_state", {29'd0, o_State_Dbg}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("midpay_rst_state", {29'd0, o_State_Dbg}, 32'd0);
    check("midpay_rst_err", {31'd0, o_Frame_Err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Reset mid-delivery: valid must drop before the next clock edge.
    tx_q = {8'hA5, 8'h01, 8'h7F, 8'h80};
    send_tx();
    check("middel_valid", {31'd0, o_Data_Valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("middel_async_valid", {31'd0, o_Data_Valid}, 32'd0);
    check("middel_async_byte", {24'd0, o_Data_Byte}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Recovery after reset.
    i_Data_Ready = 1'b1;
    expect_good_113();
    tx_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_tx();
    idle(4);
    check("recover_drained", {31'd0, o_Data_Valid}, 32'd0);

    // Final report.
    check("data_queue_empty", exp_q.size(), 32'd0);
    check("err_queue_empty", err_q.size(), 32'd0);
    check("ok_pulse_count", ok_seen, ok_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
